sample_pipe: RTL

- Parametrised multi-bit sampling pipeline; successor to the single-bit, single-polarity posedge sampler.
- Each bit has a compile-time polarity selected by generate, and the whole word has a runtime mode.
- A DEPTH-stage valid-qualified pipeline carries the samples.
- A saturating change counter runs alongside the pipeline.
- Used as the standard input-conditioning stage feeding downstream logic in diag benches, including multi-instance merge tests.

---
 rtl/sample_pipe_pkg.sv | 18 +
 rtl/sample_pipe_stage.sv | 36 +++
 rtl/sample_pipe.sv | 104 ++++++++++
 3 files changed

// File: rtl/sample_pipe_pkg.sv
// sample_pipe_pkg: mode encodings and counter helper shared by the sample_pipe files
package sample_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_HOLD = 2'd2,
        MODE_EDGE = 2'd3
    } mode_e;

    // True when a counter of width w holds its all-ones value.
    function automatic logic cnt_at_max(input logic [31:0] cnt, input int unsigned w);
        logic [31:0] top;
        top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return cnt == top;
    endfunction

endpackage

// File: rtl/sample_pipe_stage.sv
// sample_pipe_stage: one data+valid register stage of the sample pipeline
module sample_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Plain copy of the upstream stage; no stall exists in this pipeline.
    always_comb begin
        valid_d = in_valid;
        data_d  = in_data;
    end

    // Stage registers, cleared by reset so nothing stale survives it.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/sample_pipe.sv
// sample_pipe: per-bit polarity, runtime mode, DEPTH-stage valid pipeline and change counter
module sample_pipe
    import sample_pipe_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] INVERT_MASK = {WIDTH{1'b0}},
    parameter int               CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] change_cnt,
    output logic             cnt_sat
);

    mode_e            mode_s;
    logic [WIDTH-1:0] m;
    logic             accept, changed, at_max;
    logic [WIDTH-1:0] s0_data_d, s0_data_q;
    logic             s0_valid_d, s0_valid_q;
    logic [WIDTH-1:0] prev_m_d, prev_m_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sat_d, sat_q;
    logic [WIDTH-1:0] st_data [DEPTH];
    logic             st_valid [DEPTH];

    assign mode_s = mode_e'(mode);

    // Static polarity is wired per bit, so no mask mux exists at runtime.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pol
        if (INVERT_MASK[i]) begin : g_inv
            assign m[i] = ~in_data[i];
        end else begin : g_pass
            assign m[i] = in_data[i];
        end
    end

    assign accept  = in_valid && mode_s != MODE_HOLD;
    assign changed = accept && (m != prev_m_q);
    assign at_max  = cnt_at_max(32'(cnt_q), CNT_W);

    // Stage-0 result for the current mode; HOLD keeps old data and injects a bubble.
    always_comb begin
        s0_valid_d = accept;
        s0_data_d  = !accept               ? s0_data_q :
                     mode_s == MODE_PASS   ? m :
                     mode_s == MODE_INV    ? ~m :
                                             m ^ prev_m_q;
        prev_m_d   = accept ? m : prev_m_q;
    end

    // Saturating change counter; a clear overrides a simultaneous count.
    always_comb begin
        cnt_d = cnt_clr              ? '0 :
                (changed && !at_max) ? cnt_q + CNT_W'(1) :
                                       cnt_q;
        sat_d = cnt_clr              ? 1'b0 :
                (changed && at_max)  ? 1'b1 :
                                       sat_q;
    end

    // Stage-0, previous-sample and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            s0_data_q  <= '0;
            s0_valid_q <= 1'b0;
            prev_m_q   <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            s0_data_q  <= s0_data_d;
            s0_valid_q <= s0_valid_d;
            prev_m_q   <= prev_m_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
        end
    end

    assign st_data[0]  = s0_data_q;
    assign st_valid[0] = s0_valid_q;

    for (genvar k = 1; k < DEPTH; k++) begin : g_stage
        sample_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (st_valid[k-1]),
            .in_data   (st_data[k-1]),
            .out_valid (st_valid[k]),
            .out_data  (st_data[k])
        );
    end

    assign out_valid  = st_valid[DEPTH-1];
    assign out_data   = st_data[DEPTH-1];
    assign change_cnt = cnt_q;
    assign cnt_sat    = sat_q;

endmodule
